// File: rtl/keypad_mov_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, per-key frame debounce, direction map.
// Optional build macro OPPOSE_CANCEL_EN: opposing direction pairs held together cancel to zero.
module keypad_mov_scan_deb #(
  parameter int FRAMES = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic raw,
  output logic key
);
  localparam int CW = $clog2(FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAMES - 1);

  logic [CW-1:0] cnt;

  // Counter only advances while the sample disagrees; it flips the key on the
  // FRAMES-th consecutive disagreement, so it never exceeds FRAMES-1.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt <= '0;
      key <= 1'b0;
    end else if (en) begin
      if (raw != key) begin
        if (cnt == LAST) begin
          key <= raw;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module keypad_mov_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int KEY_UP          = 1,
  parameter int KEY_DOWN        = 9,
  parameter int KEY_LEFT        = 4,
  parameter int KEY_RIGHT       = 6
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] keys,
  output logic        frame_tick,
  output logic [3:0]  mov
);
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} state_t;

  state_t                             state, state_nxt;
  logic [DIV_W-1:0]                   div;
  logic                               col_done;
  logic                               frame_cap;
  logic [NUM_ROWS-1:0]                row_s1, row_s2;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  raw;
  logic [1:0]                         vld_pipe;
  logic [3:0]                         mov_nxt;

  assign col_done  = (div == DIV_LAST);
  assign frame_cap = col_done && (state == COL3);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= COL0;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    col_out   = 4'b1111;
    case (state)
      COL0: begin
        col_out = 4'b1110;
        if (col_done) state_nxt = COL1;
      end
      COL1: begin
        col_out = 4'b1101;
        if (col_done) state_nxt = COL2;
      end
      COL2: begin
        col_out = 4'b1011;
        if (col_done) state_nxt = COL3;
      end
      COL3: begin
        col_out = 4'b0111;
        if (col_done) state_nxt = COL0;
      end
      default: begin
        col_out   = 4'b1110;
        state_nxt = COL0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)       div <= '0;
    else if (col_done) div <= '0;
    else               div <= div + DIV_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  // Sample at the very end of the column period so the lines have settled.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      raw <= '0;
    end else if (col_done) begin
      for (int r = 0; r < NUM_ROWS; r++) raw[r][state] <= ~row_s2[r];
    end
  end

  // [0]: full raw frame ready -> debounce; [1]: keys updated (frame_tick) -> mov
  always_ff @(posedge sys_clk) begin
    if (sys_rst) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[0], frame_cap};
  end

  assign frame_tick = vld_pipe[1];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    keypad_mov_scan_deb #(.FRAMES(DEBOUNCE_FRAMES)) u_deb (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (vld_pipe[0]),
      .raw     (raw[k / NUM_COLS][k % NUM_COLS]),
      .key     (keys[k])
    );
  end

  always_comb begin
    mov_nxt = {keys[KEY_UP], keys[KEY_DOWN], keys[KEY_LEFT], keys[KEY_RIGHT]};
`ifdef OPPOSE_CANCEL_EN
    if (mov_nxt[3] && mov_nxt[2]) mov_nxt[3:2] = 2'b00;
    if (mov_nxt[1] && mov_nxt[0]) mov_nxt[1:0] = 2'b00;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)          mov <= '0;
    else if (vld_pipe[1]) mov <= mov_nxt;
  end
endmodule

// File: tb/tb_keypad_mov_scan.sv
// Directed bench for keypad_mov_scan: SCAN_DIV=8, DEBOUNCE_FRAMES=3, behavioural keypad matrix.
module tb_keypad_mov_scan;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        frame_tick;
  logic [3:0]  mov;
  logic [15:0] pressed = '0;
  int          tests = 0;
  int          fails = 0;
  int          n;

`ifdef OPPOSE_CANCEL_EN
  localparam logic [3:0] MOV_LR = 4'b0000;
`else
  localparam logic [3:0] MOV_LR = 4'b0011;
`endif

  keypad_mov_scan #(.SCAN_DIV(8), .DEBOUNCE_FRAMES(3)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .keys       (keys),
    .frame_tick (frame_tick),
    .mov        (mov)
  );

  always #5 sys_clk = ~sys_clk;

  // Pressed key shorts its row to the driven-low column
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (col_out[c] == 1'b0 && pressed[r*4+c]) row_in[r] = 1'b0;
  end

  task automatic step(input int cycles);
    repeat (cycles) @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (frame_tick === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    // 1: reset and scan cadence
    step(2);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_keys", keys, 16'h0);
    chk("rst_mov", mov, 4'h0);
    chk("rst_tick", frame_tick, 1'b0);
    sys_rst = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      step(1);
      if (i == 4)  chk("col0", col_out, 4'b1110);
      if (i == 12) chk("col1", col_out, 4'b1101);
      if (i == 20) chk("col2", col_out, 4'b1011);
      if (i == 28) chk("col3", col_out, 4'b0111);
      if (i == 32) chk("tick_early", frame_tick, 1'b0);
      if (i == 33) chk("tick_first", frame_tick, 1'b1);
    end
    wait_tick(n);
    chk("tick_period", n, 32);

    // 2: right key press and release
    pressed[6] = 1'b1;
    wait_tick(n);
    chk("r_tick1", n, 32);
    chk("r_keys1", keys, 16'h0);
    wait_tick(n);
    chk("r_keys2", keys, 16'h0);
    wait_tick(n);
    chk("r_keys3", keys, 16'h0040);
    chk("r_mov_lag", mov, 4'h0);
    step(1);
    chk("r_mov", mov, 4'b0001);
    chk("tick_pulse", frame_tick, 1'b0);
    pressed = '0;
    wait_tick(n);
    chk("rr_keys1", keys, 16'h0040);
    wait_tick(n);
    chk("rr_mov2", mov, 4'b0001);
    wait_tick(n);
    chk("rr_keys3", keys, 16'h0);
    step(1);
    chk("rr_mov", mov, 4'h0);

    // 3: bounce on up key never qualifies
    pressed[1] = 1'b1;
    wait_tick(n);
    wait_tick(n);
    chk("b_keys_a", keys, 16'h0);
    pressed = '0;
    wait_tick(n);
    pressed[1] = 1'b1;
    wait_tick(n);
    wait_tick(n);
    chk("b_keys_b", keys, 16'h0);
    pressed = '0;
    wait_tick(n);
    chk("b_keys_c", keys, 16'h0);
    step(1);
    chk("b_mov", mov, 4'h0);

    // 4: up+right, then an unmapped key on top
    pressed = 16'h0042;
    wait_tick(n);
    wait_tick(n);
    wait_tick(n);
    chk("ur_keys", keys, 16'h0042);
    step(1);
    chk("ur_mov", mov, 4'b1001);
    pressed = 16'h0043;
    wait_tick(n);
    wait_tick(n);
    chk("k0_keys_pre", keys, 16'h0042);
    wait_tick(n);
    chk("k0_keys", keys, 16'h0043);
    step(1);
    chk("k0_mov", mov, 4'b1001);

    // 5: left+right together
    pressed = 16'h0050;
    wait_tick(n);
    wait_tick(n);
    chk("lr_keys_pre", keys, 16'h0043);
    wait_tick(n);
    chk("lr_keys", keys, 16'h0050);
    step(1);
    chk("lr_mov", mov, MOV_LR);

    // 6: reset in the middle of a debounce and of COL2
    pressed = '0;
    wait_tick(n);
    wait_tick(n);
    wait_tick(n);
    chk("clr_keys", keys, 16'h0);
    pressed = 16'h0200;
    wait_tick(n);
    wait_tick(n);
    chk("d_keys_pre", keys, 16'h0);
    step(20);
    chk("mid_col2", col_out, 4'b1011);
    sys_rst = 1'b1;
    step(2);
    chk("mr_col", col_out, 4'b1110);
    chk("mr_keys", keys, 16'h0);
    chk("mr_mov", mov, 4'h0);
    chk("mr_tick", frame_tick, 1'b0);
    sys_rst = 1'b0;
    wait_tick(n);
    chk("mr_tick_lat", n, 33);
    chk("d_keys1", keys, 16'h0);
    wait_tick(n);
    chk("d_keys2", keys, 16'h0);
    wait_tick(n);
    chk("d_keys3", keys, 16'h0200);
    step(1);
    chk("d_mov", mov, 4'b0100);
    pressed = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
